// File: rtl/videoram_bw.sv
// Dual-port video RAM: masked CPU writes, fill engine, and a read path
// with selectable latency and read-during-write behaviour.
module videoram_bw #(
  parameter int DWIDTH  = 16,
  parameter int AWIDTH  = 8,
  parameter int RLAT    = 1,
  parameter int RDW_NEW = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DWIDTH/8-1:0]   wmask,
  input  logic [AWIDTH-1:0]     waddr,
  input  logic [DWIDTH-1:0]     wdata,
  input  logic                  re,
  input  logic [AWIDTH-1:0]     raddr,
  output logic [DWIDTH-1:0]     rdata,
  output logic                  rvalid,
  input  logic                  fill_start,
  input  logic [DWIDTH-1:0]     fill_data,
  output logic                  busy
);

  localparam int NL    = DWIDTH / 8;
  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic {IDLE, FILL} state_e;

  state_e              state_q;
  logic                busy_q;
  logic [AWIDTH-1:0]   cnt_q;
  logic [DWIDTH-1:0]   fword_q;

  logic [DWIDTH-1:0]   mem [DEPTH];

  logic [NL-1:0]       lane_en;
  logic [AWIDTH-1:0]   wa;
  logic [DWIDTH-1:0]   wd;
  logic [DWIDTH-1:0]   old_w;
  logic [DWIDTH-1:0]   rd_w;

  logic [DWIDTH-1:0]   r1_q;
  logic                v1_q;

  // Write port owner: fill engine while busy, otherwise the CPU.
  always_comb begin
    lane_en = '0;
    wa      = waddr;
    wd      = wdata;
    if (state_q == FILL) begin
      lane_en = '1;
      wa      = cnt_q;
      wd      = fword_q;
    end else begin
      lane_en = wmask & {NL{we & ~busy_q}};
    end
  end

  // Read word, optionally forwarding the lanes written this same cycle.
  always_comb begin
    old_w = mem[raddr];
    rd_w  = old_w;
    for (int i = 0; i < NL; i++) begin
      if ((RDW_NEW != 0) && (wa == raddr) && lane_en[i]) begin
        rd_w[8*i +: 8] = wd[8*i +: 8];
      end
    end
  end

  // Byte-lane array write; reset blocks any write in its cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NL; i++) begin
        if (lane_en[i]) begin
          mem[wa][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  // Fill engine: sweep every address once, busy mirrors the FILL state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      fword_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fill_start) begin
            state_q <= FILL;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            fword_q <= fill_data;
          end
        end
        FILL: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == {AWIDTH{1'b1}}) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // First read stage: capture on re, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= re;
      if (re) begin
        r1_q <= rd_w;
      end
    end
  end

  generate
    if (RLAT == 2) begin : g_lat2
      logic [DWIDTH-1:0] r2_q;
      logic              v2_q;

      // Extra output register for the two-cycle read path.
      always_ff @(posedge clk) begin
        if (reset) begin
          r2_q <= '0;
          v2_q <= 1'b0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) begin
            r2_q <= r1_q;
          end
        end
      end

      assign rdata  = r2_q;
      assign rvalid = v2_q;
    end else begin : g_lat1
      assign rdata  = r1_q;
      assign rvalid = v1_q;
    end
  endgenerate

  assign busy = busy_q;

endmodule

// File: tb/tb_videoram_bw.sv
// Bench for videoram_bw: three instances (old/new RDW, latency 2) share
// stimulus and are checked every cycle against a word-level model.
module tb_videoram_bw;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [1:0]  wmask = 2'b00;
  logic [7:0]  waddr = 8'd0;
  logic [15:0] wdata = 16'd0;
  logic        re = 1'b0;
  logic [7:0]  raddr = 8'd0;
  logic        fill_start = 1'b0;
  logic [15:0] fill_data = 16'd0;

  logic [15:0] rdata0, rdata1, rdata2;
  logic        rvalid0, rvalid1, rvalid2;
  logic        busy0, busy1, busy2;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  videoram_bw #(.DWIDTH(16), .AWIDTH(8), .RLAT(1), .RDW_NEW(0)) u0 (
    .clk(clk), .reset(reset), .we(we), .wmask(wmask), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata0),
    .rvalid(rvalid0), .fill_start(fill_start), .fill_data(fill_data),
    .busy(busy0));

  videoram_bw #(.DWIDTH(16), .AWIDTH(8), .RLAT(1), .RDW_NEW(1)) u1 (
    .clk(clk), .reset(reset), .we(we), .wmask(wmask), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata1),
    .rvalid(rvalid1), .fill_start(fill_start), .fill_data(fill_data),
    .busy(busy1));

  videoram_bw #(.DWIDTH(16), .AWIDTH(8), .RLAT(2), .RDW_NEW(0)) u2 (
    .clk(clk), .reset(reset), .we(we), .wmask(wmask), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata2),
    .rvalid(rvalid2), .fill_start(fill_start), .fill_data(fill_data),
    .busy(busy2));

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Model: memory as words, fill as "words remaining", outputs per policy.
  logic [15:0] mm [256];
  bit          mfill = 1'b0;
  int          mleft = 0;
  logic [15:0] mword = 16'd0;
  logic [15:0] e1d = 16'd0, e1dn = 16'd0, e2d = 16'd0;
  bit          e1v = 1'b0, e2v = 1'b0, ebusy = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) mm[i] = 16'hxxxx;
  end

  always @(posedge clk) begin : model
    logic [15:0] oldw, neww, wdv;
    logic [1:0]  ln;
    int          wa;
    bit          wr;
    if (reset) begin
      mfill = 1'b0;
      e1d = 16'd0; e1dn = 16'd0; e1v = 1'b0;
      e2d = 16'd0; e2v = 1'b0;
    end else begin
      e2d = e1d;
      e2v = e1v;
      wr = 1'b0; wa = 0; ln = 2'b00; wdv = 16'd0;
      if (mfill) begin
        wr = 1'b1; wa = 256 - mleft; ln = 2'b11; wdv = mword;
      end else if (we) begin
        wr = 1'b1; wa = int'(waddr); ln = wmask; wdv = wdata;
      end
      oldw = mm[raddr];
      neww = oldw;
      if (wr && wa == int'(raddr)) begin
        for (int i = 0; i < 2; i++)
          if (ln[i]) neww[8*i +: 8] = wdv[8*i +: 8];
      end
      e1v = re;
      if (re) begin
        e1d = oldw;
        e1dn = neww;
      end
      if (wr) begin
        for (int i = 0; i < 2; i++)
          if (ln[i]) mm[wa][8*i +: 8] = wdv[8*i +: 8];
      end
      if (mfill) begin
        mleft--;
        if (mleft == 0) mfill = 1'b0;
      end else if (fill_start) begin
        mfill = 1'b1;
        mleft = 256;
        mword = fill_data;
      end
    end
    ebusy = mfill;
  end

  // Per-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    if (run) begin
      chk("u0_busy", {15'd0, busy0}, {15'd0, ebusy});
      chk("u1_busy", {15'd0, busy1}, {15'd0, ebusy});
      chk("u2_busy", {15'd0, busy2}, {15'd0, ebusy});
      chk("u0_rvalid", {15'd0, rvalid0}, {15'd0, e1v});
      chk("u1_rvalid", {15'd0, rvalid1}, {15'd0, e1v});
      chk("u2_rvalid", {15'd0, rvalid2}, {15'd0, e2v});
      if (!$isunknown(e1d)) chk("u0_rdata", rdata0, e1d);
      if (!$isunknown(e1dn)) chk("u1_rdata", rdata1, e1dn);
      if (!$isunknown(e2d)) chk("u2_rdata", rdata2, e2d);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d,
                    input logic [1:0] m);
    we = 1'b1; waddr = a; wdata = d; wmask = m;
    step();
    we = 1'b0; wmask = 2'b00;
  endtask

  task automatic rd(input logic [7:0] a, input logic [15:0] exp,
                    input string nm);
    re = 1'b1; raddr = a;
    step();
    re = 1'b0;
    chk(nm, rdata0, exp);
    chk({nm, "_v"}, {15'd0, rvalid0}, 16'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy0 && n < 300) begin
      step();
      n++;
    end
    chk("fill_done", {15'd0, busy0}, 16'd0);
  endtask

  initial begin
    int b;
    step();
    step();
    run = 1'b1;
    chk("rst_rdata", rdata0, 16'd0);
    chk("rst_rvalid", {15'd0, rvalid0}, 16'd0);
    chk("rst_busy", {15'd0, busy0}, 16'd0);
    reset = 1'b0;
    step();

    // Fill 0x00A5; a second start and a CPU write during busy are dropped.
    fill_start = 1'b1; fill_data = 16'h00A5;
    step();
    fill_start = 1'b0;
    b = 0;
    while (busy0 && b < 300) begin
      b++;
      fill_start = (b == 40);
      fill_data = (b == 40) ? 16'hFFFF : 16'h00A5;
      we = (b == 90);
      waddr = 8'd3; wdata = 16'hFFFF; wmask = 2'b11;
      step();
    end
    fill_start = 1'b0; we = 1'b0; wmask = 2'b00;
    chk("busy_len", 16'(b), 16'd256);
    rd(8'd0, 16'h00A5, "fill_a0");
    rd(8'd3, 16'h00A5, "fill_a3");
    rd(8'd255, 16'h00A5, "fill_a255");

    // Full write, read back, hold between reads.
    wr(8'd5, 16'hBEEF, 2'b11);
    rd(8'd5, 16'hBEEF, "beef");
    repeat (3) step();
    chk("hold_data", rdata0, 16'hBEEF);
    chk("hold_valid", {15'd0, rvalid0}, 16'd0);

    // Byte masks.
    wr(8'd5, 16'h1234, 2'b01);
    rd(8'd5, 16'hBE34, "mask_lo");
    wr(8'd5, 16'h5600, 2'b10);
    rd(8'd5, 16'h5634, "mask_hi");

    // Read during write, both policies.
    wr(8'd9, 16'h1111, 2'b11);
    we = 1'b1; waddr = 8'd9; wdata = 16'h2222; wmask = 2'b11;
    re = 1'b1; raddr = 8'd9;
    step();
    we = 1'b0; re = 1'b0; wmask = 2'b00;
    chk("rdw_old", rdata0, 16'h1111);
    chk("rdw_new", rdata1, 16'h2222);
    wr(8'd9, 16'h1111, 2'b11);
    we = 1'b1; waddr = 8'd9; wdata = 16'h2222; wmask = 2'b10;
    re = 1'b1; raddr = 8'd9;
    step();
    we = 1'b0; re = 1'b0; wmask = 2'b00;
    chk("rdw_old_m", rdata0, 16'h1111);
    chk("rdw_new_m", rdata1, 16'h2211);

    // Latency-2 streaming.
    for (int i = 0; i < 8; i++) wr(8'(i), 16'(16'h1000 + i), 2'b11);
    for (int i = 0; i < 8; i++) begin
      re = 1'b1; raddr = 8'(i);
      step();
      if (i == 0) begin
        chk("l2_first_v", {15'd0, rvalid2}, 16'd0);
      end else begin
        chk("l2_v", {15'd0, rvalid2}, 16'd1);
        chk("l2_d", rdata2, 16'(16'h1000 + i - 1));
      end
    end
    re = 1'b0;
    step();
    chk("l2_last_v", {15'd0, rvalid2}, 16'd1);
    chk("l2_last_d", rdata2, 16'h1007);
    step();
    chk("l2_end_v", {15'd0, rvalid2}, 16'd0);

    // Reset in the middle of a fill.
    fill_start = 1'b1; fill_data = 16'h0001;
    step();
    fill_start = 1'b0;
    wait_idle();
    fill_start = 1'b1; fill_data = 16'h7777;
    step();
    fill_start = 1'b0;
    repeat (19) step();
    reset = 1'b1; re = 1'b1; raddr = 8'd0;
    step();
    reset = 1'b0; re = 1'b0;
    chk("mid_busy", {15'd0, busy0}, 16'd0);
    chk("mid_rvalid", {15'd0, rvalid0}, 16'd0);
    chk("mid_rdata", rdata0, 16'd0);
    chk("mid_rdata2", rdata2, 16'd0);
    for (int i = 0; i < 19; i++) rd(8'(i), 16'h7777, "mid_filled");
    rd(8'd200, 16'h0001, "mid_kept");
    step();
    step();

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/videoram_bw.md
Name: videoram_bw

Overview:
- Next-generation video RAM: one synchronous write port and one independent synchronous read port.
- Adds per-byte write masking, a selectable read-during-write policy, configurable read latency with a valid strobe, and a hardware fill engine that clears or paints the whole array.
- Sits between the CPU/blitter write path and the display scan-out read path.

Parameters:
- DWIDTH, 16, data word width in bits; must be a multiple of 8.
- AWIDTH, 8, address width; depth is 2**AWIDTH words.
- RLAT, 1, read latency in cycles; legal values are 1 and 2.
- RDW_NEW, 0, read-during-write policy at the same address: 0 returns old data, 1 returns new (merged) data.

Ports:
- clk  in  1  single clock; all logic is on the posedge.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write strobe.
- wmask  in  DWIDTH/8  byte-lane enables for the write; bit i covers wdata[8i+7:8i].
- waddr  in  AWIDTH  write address.
- wdata  in  DWIDTH  write data.
- re  in  1  read strobe.
- raddr  in  AWIDTH  read address.
- rdata  out  DWIDTH  read data; holds its value between reads.
- rvalid  out  1  one-cycle pulse when rdata carries the result of a read.
- fill_start  in  1  starts a whole-array fill.
- fill_data  in  DWIDTH  fill word; sampled on the fill_start cycle.
- busy  out  1  high while the fill engine owns the write port.

Behaviour:
- Reset:
  - rdata=0, rvalid=0, busy=0; fill FSM goes to IDLE; fill counter=0; read pipeline cleared.
  - Memory contents are not reset.
  - Reset has priority over every other input in the same cycle.
- Writes:
  - Accepted when we=1 and busy=0.
  - Each lane with wmask[i]=1 updates; lanes with wmask[i]=0 keep their old bytes.
  - wmask=0 writes nothing.
  - we while busy=1 is silently dropped (no queueing).
- Reads:
  - Accepted whenever re=1, including while busy.
  - RLAT=1: a read at cycle N updates rdata at the edge ending cycle N; rvalid is high during cycle N+1.
  - RLAT=2: one extra output register; rdata/rvalid appear one cycle later.
  - Back-to-back reads give one result per cycle.
  - re=0: rvalid=0 in the corresponding slot and rdata holds.
- Read-during-write, same address, same cycle (CPU write or fill write):
  - RDW_NEW=0 returns the pre-write word.
  - RDW_NEW=1 returns the word after the mask merge: masked lanes from wdata, others old. For fill writes the mask is all ones.
  - Different addresses never interact.
- Fill FSM, states IDLE and FILL:
  - IDLE -> FILL on fill_start=1; latch fill_data; counter=0.
  - fill_start is ignored while in FILL.
  - FILL: write the fill word, full mask, to address = counter each cycle, then increment.
  - After writing address 2**AWIDTH-1, return to IDLE; the counter wraps to 0.
  - busy=1 exactly during FILL cycles. With fill_start at cycle N, busy is high for cycles N+1 .. N+2**AWIDTH, then low.
  - A CPU write in cycle N (busy=0) is performed, then overwritten by the fill.
- Reset mid-fill: abort immediately; busy=0 next cycle. Addresses already filled keep the fill word; the rest keep prior contents.
- Widths: internal write enable per lane is wmask & {DWIDTH/8{we & ~busy}} in CPU mode, all ones in FILL; the counter is AWIDTH bits.

Test Plan:
- RLAT=1, RDW_NEW=0, DWIDTH=16: write 0xBEEF to address 5 with mask 2'b11; read address 5 next cycle -> rdata=0xBEEF with rvalid=1 one cycle later; rdata still 0xBEEF 3 cycles after, with rvalid=0.
- Byte mask: address 5 holds 0xBEEF; write 0x1234 with mask 2'b01; read -> 0xBE34. Then write 0x5600 with mask 2'b10; read -> 0x5634.
- Read-during-write to address 9 (old 0x1111, write 0x2222, mask 2'b11) in the same cycle -> RDW_NEW=0 returns 0x1111; RDW_NEW=1 returns 0x2222. A masked variant (mask 2'b10, RDW_NEW=1) returns 0x2211.
- Fill: fill_start with fill_data=0x00A5 at cycle 10 (AWIDTH=8) -> busy high for cycles 11..266. A we to address 3 (0xFFFF) at cycle 100 is dropped; a second fill_start at cycle 50 is ignored. Afterwards reads of addresses 0, 3 and 255 all return 0x00A5.
- Reset mid-fill: fill 0x7777 over memory pre-loaded with 0x0001; assert reset at busy cycle 20 -> busy=0, rvalid=0, rdata=0 the next cycle. Addresses 0..18 read 0x7777; address 200 reads 0x0001.
- RLAT=2 streaming: reads of addresses 0..7 back-to-back -> rvalid high for 8 consecutive cycles starting 2 cycles after the first re. Data appears in order and matches the contents written earlier.
